sha256_msg_sched: RTL

SHA-256 message-schedule sequencer: the initiator that drives the 32-bit word register file's one write port and four read ports. It loads the 16 words of a message block into the register file, expands them to W[0..63] in place, and streams every W[t] to the compression round over a valid/ready handshake. It sits between the block-input stage and the round datapath.

---
 rtl/sha256_pkg.sv | 36 +++
 rtl/sha256_sched_sigma.sv | 15 +
 rtl/sha256_msg_sched.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// SHA-256 schedule package: FSM states, block/schedule sizes and sigma
// functions shared by the schedule sequencer and the round datapath.
package sha256_pkg;

  localparam int SCHED_WORDS = 64;
  localparam int BLOCK_WORDS = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
`ifdef SHA256_SCHED_ZEROIZE_EN
    S_DRAIN,
    S_ZERO
`else
    S_DRAIN
`endif
  } state_t;

  function automatic logic [31:0] sig0(
    input logic [31:0] x
  );
    return {x[6:0], x[31:7]}
         ^ {x[17:0], x[31:18]}
         ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(
    input logic [31:0] x
  );
    return {x[16:0], x[31:17]}
         ^ {x[18:0], x[31:19]}
         ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_sched_sigma.sv
// Combinational schedule adder: o_sum = sig1(a) + b + sig0(c) + d mod 2^32.
// Ports: i_a = W[t-2], i_b = W[t-7], i_c = W[t-15], i_d = W[t-16], o_sum = W[t].
module sha256_sched_sigma
  import sha256_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_c,
  input  logic [31:0] i_d,
  output logic [31:0] o_sum
);

  assign o_sum = sig1(i_a) + i_b + sig0(i_c) + i_d;

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule sequencer: loads 16 block words into the word
// register file, expands W[16..63] in place and streams W[t] out.
// Ports: clk/rst (async, active-low); i_start; i_in_valid/o_in_ready/
// i_in_data block input; o_rf_addr_wr/o_rf_data_wr/i_rf_data_rd write port;
// o_rf_addr_a..d/i_rf_data_a..d read ports (W[t-2], W[t-7], W[t-15],
// W[t-16]); o_w_valid/i_w_ready/o_w_data/o_w_index output; o_busy; o_done.
// Option: SHA256_SCHED_ZEROIZE_EN clears W[0..63] before done.
module sha256_msg_sched
  import sha256_pkg::*;
#(
  parameter int BASE_ADDR = 0,
  parameter int ROUNDS    = SCHED_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_in_data,
  output logic [7:0]  o_rf_addr_wr,
  output logic [31:0] o_rf_data_wr,
  input  logic [31:0] i_rf_data_rd,
  output logic [7:0]  o_rf_addr_a,
  output logic [7:0]  o_rf_addr_b,
  output logic [7:0]  o_rf_addr_c,
  output logic [7:0]  o_rf_addr_d,
  input  logic [31:0] i_rf_data_a,
  input  logic [31:0] i_rf_data_b,
  input  logic [31:0] i_rf_data_c,
  input  logic [31:0] i_rf_data_d,
  output logic        o_w_valid,
  input  logic        i_w_ready,
  output logic [31:0] o_w_data,
  output logic [5:0]  o_w_index,
  output logic        o_busy,
  output logic        o_done
);

  localparam logic [7:0] BASE = 8'(BASE_ADDR);
  localparam logic [5:0] LAST = 6'(ROUNDS - 1);
  localparam logic [5:0] LDLAST = 6'(BLOCK_WORDS - 1);

  state_t      r_state, w_state_nx;
  logic [5:0]  r_cnt, w_cnt_nx;
  logic [31:0] r_w_data, w_w_data_nx;
  logic [5:0]  r_w_index, w_w_index_nx;
  logic        r_w_valid, w_w_valid_nx;
  logic        r_done, w_done_nx;
  logic [7:0]  r_addr_wr;
  logic [7:0]  w_wa;
  logic [31:0] w_wd;
  logic [31:0] w_sum;
  logic [7:0]  w_t8;
  logic        w_hi;
  logic        w_adv;

  assign w_t8  = {2'b00, r_cnt};
  assign w_hi  = r_cnt[5] | r_cnt[4];
  assign w_adv = !r_w_valid || i_w_ready;

  // Read taps only matter in STREAM; elsewhere they park on BASE.
  always_comb begin
    o_rf_addr_a = BASE;
    o_rf_addr_b = BASE;
    o_rf_addr_c = BASE;
    o_rf_addr_d = BASE;
    if (r_state == S_STREAM) begin
      if (w_hi) begin
        o_rf_addr_a = BASE + w_t8 - 8'd2;
        o_rf_addr_b = BASE + w_t8 - 8'd7;
        o_rf_addr_c = BASE + w_t8 - 8'd15;
        o_rf_addr_d = BASE + w_t8 - 8'd16;
      end else begin
        o_rf_addr_d = BASE + w_t8;
      end
    end
  end

  sha256_sched_sigma u_sigma (
    .i_a   (i_rf_data_a),
    .i_b   (i_rf_data_b),
    .i_c   (i_rf_data_c),
    .i_d   (i_rf_data_d),
    .o_sum (w_sum)
  );

  // The file writes every edge: idle cycles write the readback of the
  // last address to itself.
  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_w_data_nx  = r_w_data;
    w_w_index_nx = r_w_index;
    w_w_valid_nx = r_w_valid;
    w_done_nx    = 1'b0;
    w_wa         = r_addr_wr;
    w_wd         = i_rf_data_rd;
    o_in_ready   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nx = S_LOAD;
          w_cnt_nx   = 6'd0;
        end
      end
      S_LOAD: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          w_wa     = BASE + w_t8;
          w_wd     = i_in_data;
          w_cnt_nx = r_cnt + 6'd1;
          if (r_cnt == LDLAST) begin
            w_state_nx = S_STREAM;
            w_cnt_nx   = 6'd0;
          end
        end
      end
      S_STREAM: begin
        if (w_adv) begin
          w_w_valid_nx = 1'b1;
          w_w_index_nx = r_cnt;
          w_cnt_nx     = r_cnt + 6'd1;
          if (w_hi) begin
            w_w_data_nx = w_sum;
            w_wa        = BASE + w_t8;
            w_wd        = w_sum;
          end else begin
            w_w_data_nx = i_rf_data_d;
          end
          if (r_cnt == LAST) begin
            w_state_nx = S_DRAIN;
            w_cnt_nx   = 6'd0;
          end
        end
      end
      S_DRAIN: begin
        if (r_w_valid && i_w_ready) begin
          w_w_valid_nx = 1'b0;
`ifdef SHA256_SCHED_ZEROIZE_EN
          w_state_nx   = S_ZERO;
          w_cnt_nx     = 6'd0;
`else
          w_done_nx    = 1'b1;
          w_state_nx   = S_IDLE;
`endif
        end
      end
`ifdef SHA256_SCHED_ZEROIZE_EN
      S_ZERO: begin
        w_wa     = BASE + w_t8;
        w_wd     = 32'd0;
        w_cnt_nx = r_cnt + 6'd1;
        if (r_cnt == LAST) begin
          w_done_nx  = 1'b1;
          w_state_nx = S_IDLE;
          w_cnt_nx   = 6'd0;
        end
      end
`endif
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 6'd0;
      r_w_data  <= 32'd0;
      r_w_index <= 6'd0;
      r_w_valid <= 1'b0;
      r_done    <= 1'b0;
      r_addr_wr <= BASE;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_w_data  <= w_w_data_nx;
      r_w_index <= w_w_index_nx;
      r_w_valid <= w_w_valid_nx;
      r_done    <= w_done_nx;
      r_addr_wr <= w_wa;
    end
  end

  assign o_rf_addr_wr = w_wa;
  assign o_rf_data_wr = w_wd;
  assign o_w_valid    = r_w_valid;
  assign o_w_data     = r_w_data;
  assign o_w_index    = r_w_index;
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = r_done;

endmodule
